// File: rtl/pong_ball_engine.sv
// pong_ball_engine: per-frame Pong game logic sitting just upstream of the
// pixel colour mux. Produces a registered ball-pixel flag for the current scan
// position, plus ball position, scores and game state.
// Optional build macro: PONG_SPEEDUP_EN. When defined, a per-rally speed
// register grows by one on each paddle hit, up to twice the base speed. When
// undefined, the ball always moves at the constant SPEED.
module pong_ball_engine #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int BALL_SIZE   = 8,
  parameter int PADDLE_W    = 8,
  parameter int PADDLE_H    = 64,
  parameter int PADDLE_XL   = 16,
  parameter int PADDLE_XR   = 616,
  parameter int SPEED       = 2,
  parameter int WIN_SCORE   = 9,
  parameter int HOLD_FRAMES = 60
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [9:0] row,
  input  logic [9:0] col,
  input  logic       blank,
  input  logic       serve,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_pixel,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] game_state,
  output logic       point_pulse
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PLAY   = 2'd1,
    S_SCORED = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  // All motion arithmetic is done on 11 bits so that subtraction never wraps.
  localparam logic [10:0] BALL_C  = 11'(BALL_SIZE);
  localparam logic [10:0] PH_C    = 11'(PADDLE_H);
  localparam logic [10:0] L_FACE  = 11'(PADDLE_XL + PADDLE_W);
  localparam logic [10:0] XR_C    = 11'(PADDLE_XR);
  localparam logic [10:0] R_FACE  = 11'(PADDLE_XR - BALL_SIZE);
  localparam logic [10:0] X_MAX   = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic [10:0] Y_MAX   = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic [10:0] SPEED_C = 11'(SPEED);
  localparam logic [9:0]  X_CTR   = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0]  Y_CTR   = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0]  VACT_R  = 10'(V_ACTIVE);
  localparam logic [3:0]  WIN_C   = 4'(WIN_SCORE);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);

  state_t            state_q, state_d;
  logic [9:0]        row_q;
  logic [9:0]        ball_x_q, ball_x_d;
  logic [9:0]        ball_y_q, ball_y_d;
  logic              dx_right_q, dx_right_d;
  logic              dy_down_q, dy_down_d;
  logic [3:0]        score_l_q, score_l_d;
  logic [3:0]        score_r_q, score_r_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              pixel_q, pixel_d;
  logic              pulse_q, pulse_d;

  logic              tick_s;
  logic [10:0]       spd_s;
  logic [10:0]       x_s, y_s, pl_s, pr_s, col_s, row_s;
  logic              hit_l_s, hit_r_s;

  assign tick_s = (row == VACT_R) && (row_q != VACT_R);

  assign x_s   = {1'b0, ball_x_q};
  assign y_s   = {1'b0, ball_y_q};
  assign pl_s  = {1'b0, paddle_l_y};
  assign pr_s  = {1'b0, paddle_r_y};
  assign col_s = {1'b0, col};
  assign row_s = {1'b0, row};

  // Contact tests use the ball row before this tick's vertical move and the
  // paddle row sampled on this tick.
  assign hit_l_s = (x_s <= L_FACE + spd_s) && (x_s >= L_FACE) &&
                   (y_s + BALL_C > pl_s) && (y_s < pl_s + PH_C);
  assign hit_r_s = (x_s + spd_s + BALL_C >= XR_C) && (x_s + BALL_C <= XR_C) &&
                   (y_s + BALL_C > pr_s) && (y_s < pr_s + PH_C);

`ifdef PONG_SPEEDUP_EN
  localparam logic [10:0] SPEED_MAX = 11'(2 * SPEED);
  logic [10:0] speed_q, speed_d;
  logic        paddle_hit_s, enter_idle_s;

  assign paddle_hit_s = tick_s && (state_q == S_PLAY) && (dx_right_q ? hit_r_s : hit_l_s);
  assign enter_idle_s = (state_d == S_IDLE) && (state_q != S_IDLE);

  // Rally speed: reload at the start of each rally, grow on each paddle hit up to the cap.
  always_comb begin
    speed_d = speed_q;
    if (enter_idle_s) begin
      speed_d = SPEED_C;
    end else if (paddle_hit_s && (speed_q < SPEED_MAX)) begin
      speed_d = speed_q + 11'd1;
    end else begin
      speed_d = speed_q;
    end
  end

  // Rally speed register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      speed_q <= SPEED_C;
    end else begin
      speed_q <= speed_d;
    end
  end

  assign spd_s = speed_q;
`else
  assign spd_s = SPEED_C;
`endif

  // Ball coverage of the current scan position, registered for one cycle of latency.
  always_comb begin
    pixel_d = 1'b0;
    if (!blank && (col_s >= x_s) && (col_s < x_s + BALL_C) &&
        (row_s >= y_s) && (row_s < y_s + BALL_C)) begin
      pixel_d = 1'b1;
    end else begin
      pixel_d = 1'b0;
    end
  end

  // Game FSM next state: motion, bounces, scoring and serve, evaluated once per frame tick.
  always_comb begin
    state_d    = state_q;
    ball_x_d   = ball_x_q;
    ball_y_d   = ball_y_q;
    dx_right_d = dx_right_q;
    dy_down_d  = dy_down_q;
    score_l_d  = score_l_q;
    score_r_d  = score_r_q;
    hold_d     = hold_q;
    pulse_d    = 1'b0;
    if (tick_s) begin
      case (state_q)
        S_IDLE: begin
          ball_x_d = X_CTR;
          ball_y_d = Y_CTR;
          // dx is left as it was: it still points at whoever lost the last point.
          if (serve) begin
            state_d   = S_PLAY;
            dy_down_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_PLAY: begin
          if (!dy_down_q) begin
            if (y_s < spd_s) begin
              ball_y_d  = 10'd0;
              dy_down_d = 1'b1;
            end else begin
              ball_y_d = 10'(y_s - spd_s);
            end
          end else begin
            if (y_s + spd_s > Y_MAX) begin
              ball_y_d  = 10'(Y_MAX);
              dy_down_d = 1'b0;
            end else begin
              ball_y_d = 10'(y_s + spd_s);
            end
          end
          if (!dx_right_q) begin
            if (hit_l_s) begin
              ball_x_d   = 10'(L_FACE);
              dx_right_d = 1'b1;
            end else if (x_s < spd_s) begin
              if (score_r_q < WIN_C) begin
                score_r_d = score_r_q + 4'd1;
              end else begin
                score_r_d = score_r_q;
              end
              pulse_d = 1'b1;
              hold_d  = HOLD_ZERO;
              state_d = S_SCORED;
            end else begin
              ball_x_d = 10'(x_s - spd_s);
            end
          end else begin
            if (hit_r_s) begin
              ball_x_d   = 10'(R_FACE);
              dx_right_d = 1'b0;
            end else if (x_s + spd_s > X_MAX) begin
              if (score_l_q < WIN_C) begin
                score_l_d = score_l_q + 4'd1;
              end else begin
                score_l_d = score_l_q;
              end
              pulse_d = 1'b1;
              hold_d  = HOLD_ZERO;
              state_d = S_SCORED;
            end else begin
              ball_x_d = 10'(x_s + spd_s);
            end
          end
        end
        S_SCORED: begin
          if (hold_q == HOLD_LAST) begin
            hold_d   = HOLD_ZERO;
            ball_x_d = X_CTR;
            ball_y_d = Y_CTR;
            if ((score_l_q == WIN_C) || (score_r_q == WIN_C)) begin
              state_d = S_OVER;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            hold_d = hold_q + HOLD_ONE;
          end
        end
        S_OVER: begin
          if (serve) begin
            score_l_d  = 4'd0;
            score_r_d  = 4'd0;
            ball_x_d   = X_CTR;
            ball_y_d   = Y_CTR;
            dx_right_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            state_d = S_OVER;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State, position, score, scan-row history and output registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      row_q      <= 10'd0;
      state_q    <= S_IDLE;
      ball_x_q   <= X_CTR;
      ball_y_q   <= Y_CTR;
      dx_right_q <= 1'b1;
      dy_down_q  <= 1'b1;
      score_l_q  <= 4'd0;
      score_r_q  <= 4'd0;
      hold_q     <= HOLD_ZERO;
      pixel_q    <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      row_q      <= row;
      state_q    <= state_d;
      ball_x_q   <= ball_x_d;
      ball_y_q   <= ball_y_d;
      dx_right_q <= dx_right_d;
      dy_down_q  <= dy_down_d;
      score_l_q  <= score_l_d;
      score_r_q  <= score_r_d;
      hold_q     <= hold_d;
      pixel_q    <= pixel_d;
      pulse_q    <= pulse_d;
    end
  end

  assign ball_x      = ball_x_q;
  assign ball_y      = ball_y_q;
  assign ball_pixel  = pixel_q;
  assign score_l     = score_l_q;
  assign score_r     = score_r_q;
  assign game_state  = state_q;
  assign point_pulse = pulse_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed self-checking bench for pong_ball_engine. Frame ticks are produced
// by pulsing row to 480 for one clock; expected positions are hand-derived.
`timescale 1ns/1ps
module tb_pong_ball_engine;

  logic       clk;
  logic       rst;
  logic [9:0] row;
  logic [9:0] col;
  logic       blank;
  logic       serve;
  logic [9:0] paddle_l_y;
  logic [9:0] paddle_r_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       ball_pixel;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic [1:0] game_state;
  logic       point_pulse;

  int n_compared   = 0;
  int n_mismatched = 0;

  pong_ball_engine dut (
    .CLOCK_50   (clk),
    .reset      (rst),
    .row        (row),
    .col        (col),
    .blank      (blank),
    .serve      (serve),
    .paddle_l_y (paddle_l_y),
    .paddle_r_y (paddle_r_y),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .ball_pixel (ball_pixel),
    .score_l    (score_l),
    .score_r    (score_r),
    .game_state (game_state),
    .point_pulse(point_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_compared++;
    if (got != exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One frame tick: row sits at 480 for exactly one clock.
  task automatic tick(input logic srv);
    @(negedge clk);
    serve = srv;
    row   = 10'd480;
    @(negedge clk);
    row   = 10'd0;
    serve = 1'b0;
  endtask

  task automatic ticks(input int n, input logic srv);
    for (int i = 0; i < n; i++) tick(srv);
  endtask

  int pv_row [8] = '{236, 236, 236, 243, 244, 236, 236, 235};
  int pv_col [8] = '{316, 324, 323, 316, 316, 315, 316, 320};
  int pv_blk [8] = '{0,   0,   0,   0,   0,   0,   1,   0};
  int pv_exp [8] = '{1,   0,   1,   1,   0,   0,   0,   0};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; row = 10'd0; col = 10'd0; blank = 1'b1; serve = 1'b0;
    paddle_l_y = 10'd0; paddle_r_y = 10'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_x", int'(ball_x), 316);
    check_eq("rst_y", int'(ball_y), 236);
    check_eq("rst_state", int'(game_state), 0);
    check_eq("rst_score_l", int'(score_l), 0);
    check_eq("rst_score_r", int'(score_r), 0);
    check_eq("rst_pixel", int'(ball_pixel), 0);
    check_eq("rst_pulse", int'(point_pulse), 0);
    rst = 1'b0;

    // Pixel path around the centred ball (316..323, 236..243).
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      row = 10'(pv_row[i]); col = 10'(pv_col[i]); blank = pv_blk[i][0];
      if (i == 0) begin
        #1 check_eq("pix_latency", int'(ball_pixel), 0);
      end
      @(negedge clk);
      check_eq($sformatf("pix_vec%0d", i), int'(ball_pixel), pv_exp[i]);
    end
    @(negedge clk);
    row = 10'd0; col = 10'd0; blank = 1'b1;

    // Rally A: right paddle out of the way, left player scores.
    paddle_r_y = 10'd0; paddle_l_y = 10'd0;
    tick(1'b1);
    check_eq("serve_state", int'(game_state), 1);
    ticks(10, 1'b0);
    check_eq("move10_x", int'(ball_x), 336);
    check_eq("move10_y", int'(ball_y), 256);
    ticks(148, 1'b0);
    check_eq("pre_score_x", int'(ball_x), 632);
    check_eq("pre_score_y", int'(ball_y), 394);
    check_eq("pre_score_pulse", int'(point_pulse), 0);
    tick(1'b0);
    check_eq("scoreA_state", int'(game_state), 2);
    check_eq("scoreA_l", int'(score_l), 1);
    check_eq("scoreA_r", int'(score_r), 0);
    check_eq("scoreA_pulse", int'(point_pulse), 1);
    check_eq("scoreA_x", int'(ball_x), 632);
    check_eq("scoreA_y", int'(ball_y), 392);
    @(negedge clk);
    check_eq("scoreA_pulse_end", int'(point_pulse), 0);
    ticks(59, 1'b1);
    check_eq("hold59_state", int'(game_state), 2);
    check_eq("hold59_x", int'(ball_x), 632);
    tick(1'b0);
    check_eq("hold60_state", int'(game_state), 0);
    check_eq("hold60_x", int'(ball_x), 316);
    check_eq("hold60_y", int'(ball_y), 236);

    // Rally B: right paddle hit, top wall, left paddle hit.
    paddle_r_y = 10'd400; paddle_l_y = 10'd120;
    tick(1'b1);
    ticks(145, 1'b0);
    check_eq("r_approach_x", int'(ball_x), 606);
    check_eq("r_approach_y", int'(ball_y), 420);
    tick(1'b0);
    check_eq("r_hit_x", int'(ball_x), 608);
    check_eq("r_hit_y", int'(ball_y), 418);
    tick(1'b0);
    check_eq("r_hit_dx", int'(ball_x), 606);
    ticks(208, 1'b0);
    check_eq("top_reach_y", int'(ball_y), 0);
    check_eq("top_reach_x", int'(ball_x), 190);
    tick(1'b0);
    check_eq("top_clamp_y", int'(ball_y), 0);
    tick(1'b0);
    check_eq("top_bounce_y", int'(ball_y), 2);
    check_eq("top_bounce_x", int'(ball_x), 186);
    ticks(80, 1'b0);
    check_eq("l_approach_x", int'(ball_x), 26);
    check_eq("l_approach_y", int'(ball_y), 162);
    tick(1'b0);
    check_eq("l_hit_x", int'(ball_x), 24);
    check_eq("l_hit_y", int'(ball_y), 164);
    tick(1'b0);
    check_eq("l_hit_dx", int'(ball_x), 26);
    check_eq("l_hit_state", int'(game_state), 1);

    // Asynchronous reset in the middle of play, with the ball pixel lit.
    @(negedge clk);
    row = 10'd166; col = 10'd26; blank = 1'b0;
    @(negedge clk);
    check_eq("play_pixel", int'(ball_pixel), 1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_x", int'(ball_x), 316);
    check_eq("arst_y", int'(ball_y), 236);
    check_eq("arst_state", int'(game_state), 0);
    check_eq("arst_score_l", int'(score_l), 0);
    check_eq("arst_pixel", int'(ball_pixel), 0);
    @(negedge clk);
    rst = 1'b0; row = 10'd0; col = 10'd0; blank = 1'b1;

    // Rally C: left paddle misses, right player scores, next serve goes left.
    paddle_r_y = 10'd400; paddle_l_y = 10'd300;
    tick(1'b1);
    ticks(146 + 291, 1'b0);
    check_eq("c_approach_x", int'(ball_x), 26);
    tick(1'b0);
    check_eq("pass_x", int'(ball_x), 24);
    check_eq("pass_y", int'(ball_y), 164);
    tick(1'b0);
    check_eq("pass2_x", int'(ball_x), 22);
    ticks(11, 1'b0);
    check_eq("edge_x", int'(ball_x), 0);
    check_eq("edge_state", int'(game_state), 1);
    tick(1'b0);
    check_eq("scoreC_state", int'(game_state), 2);
    check_eq("scoreC_r", int'(score_r), 1);
    check_eq("scoreC_l", int'(score_l), 0);
    check_eq("scoreC_pulse", int'(point_pulse), 1);
    check_eq("scoreC_x", int'(ball_x), 0);
    check_eq("scoreC_y", int'(ball_y), 190);
    ticks(60, 1'b0);
    check_eq("c_idle_state", int'(game_state), 0);
    tick(1'b1);
    tick(1'b0);
    check_eq("serve_left_x", int'(ball_x), 314);
    check_eq("serve_left_y", int'(ball_y), 238);

    // Game over: left player takes nine identical points.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    paddle_r_y = 10'd0;
    for (int r = 0; r < 9; r++) begin
      tick(1'b1);
      ticks(159, 1'b0);
      check_eq($sformatf("go_score%0d", r + 1), int'(score_l), r + 1);
      check_eq($sformatf("go_scored%0d", r + 1), int'(game_state), 2);
      if (r < 8) begin
        ticks(60, 1'b0);
        check_eq($sformatf("go_idle%0d", r + 1), int'(game_state), 0);
      end
    end
    ticks(59, 1'b0);
    check_eq("go_hold59", int'(game_state), 2);
    tick(1'b0);
    check_eq("go_state", int'(game_state), 3);
    check_eq("go_score_l", int'(score_l), 9);
    tick(1'b0);
    check_eq("go_wait", int'(game_state), 3);
    tick(1'b1);
    check_eq("go_restart_state", int'(game_state), 0);
    check_eq("go_restart_l", int'(score_l), 0);
    check_eq("go_restart_r", int'(score_r), 0);
    check_eq("go_restart_x", int'(ball_x), 316);
    tick(1'b1);
    tick(1'b0);
    check_eq("go_serve_x", int'(ball_x), 318);
    check_eq("go_serve_state", int'(game_state), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
